// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: operand forwarding, load-use stall, branch flush,
// and a two-state sequencer that holds the front end while a multicycle op occupies stage C.
module hazard_ctrl #(
  parameter int ADDR_WIDTH = 5,
  parameter int MC_LATENCY = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] Rs1BH,
  input  logic [ADDR_WIDTH-1:0] Rs2BH,
  input  logic [ADDR_WIDTH-1:0] Rs1CH,
  input  logic [ADDR_WIDTH-1:0] Rs2CH,
  input  logic [ADDR_WIDTH-1:0] RdCH,
  input  logic                  MemReadCH,
  input  logic                  MultiCycleCH,
  input  logic                  PCSrcCH,
  input  logic [ADDR_WIDTH-1:0] RdDH,
  input  logic                  RegWriteDH,
  input  logic [ADDR_WIDTH-1:0] RdEH,
  input  logic                  RegWriteEH,
  output logic [1:0]            ForwardAH,
  output logic [1:0]            ForwardBH,
  output logic                  StallAH,
  output logic                  StallBH,
  output logic                  StallCH,
  output logic                  FlushBH,
  output logic                  FlushCH,
  output logic                  FlushDH,
  output logic                  BusyH,
  output logic [CNT_WIDTH-1:0]  StallCntH
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [7:0] MC_LOAD  = 8'(MC_LATENCY - 2);
  localparam bit         MC_MULTI = (MC_LATENCY > 1);

  state_t     state, nextState;
  logic [7:0] cnt, nextCnt;
  logic       mcStall, loadUse;
  logic       stallA, stallB, stallC, flushB, flushC, flushD;
  logic [1:0] fwdA, fwdB;

  always_comb begin
    fwdA = 2'b00;
    if (RegWriteDH && RdDH != '0 && RdDH == Rs1CH)      fwdA = 2'b10;
    else if (RegWriteEH && RdEH != '0 && RdEH == Rs1CH) fwdA = 2'b01;
    fwdB = 2'b00;
    if (RegWriteDH && RdDH != '0 && RdDH == Rs2CH)      fwdB = 2'b10;
    else if (RegWriteEH && RdEH != '0 && RdEH == Rs2CH) fwdB = 2'b01;
  end

  always_comb begin
    nextState = state;
    nextCnt   = cnt;
    mcStall   = 1'b0;
    stallA    = 1'b0;
    stallB    = 1'b0;
    stallC    = 1'b0;
    flushB    = 1'b0;
    flushC    = 1'b0;
    flushD    = 1'b0;
    loadUse   = MemReadCH && RdCH != '0 && (RdCH == Rs1BH || RdCH == Rs2BH);
    case (state)
      IDLE: if (MultiCycleCH && MC_MULTI) begin
        mcStall   = 1'b1;
        nextState = BUSY;
        nextCnt   = MC_LOAD;
      end
      BUSY: if (cnt != '0) begin
        mcStall = 1'b1;
        nextCnt = cnt - 8'd1;
      end else begin
        // Release cycle: the op leaves C, so MultiCycleCH is ignored here.
        nextState = IDLE;
      end
    endcase
    if (mcStall) begin
      stallA = 1'b1;
      stallB = 1'b1;
      stallC = 1'b1;
      flushD = 1'b1;
    end else if (PCSrcCH) begin
      flushB = 1'b1;
      flushC = 1'b1;
    end else if (state == IDLE && loadUse) begin
      stallA = 1'b1;
      stallB = 1'b1;
      flushC = 1'b1;
    end
  end

  assign ForwardAH = rst_n ? fwdA : 2'b00;
  assign ForwardBH = rst_n ? fwdB : 2'b00;
  assign StallAH   = rst_n & stallA;
  assign StallBH   = rst_n & stallB;
  assign StallCH   = rst_n & stallC;
  assign FlushBH   = rst_n & flushB;
  assign FlushCH   = rst_n & flushC;
  assign FlushDH   = rst_n & flushD;
  assign BusyH     = rst_n & (state == BUSY);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nextState;
      cnt   <= nextCnt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      StallCntH <= '0;
    else if ((StallCH || StallBH) && StallCntH != '1)
      StallCntH <= StallCntH + CNT_WIDTH'(1);
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed vector table, multicycle/reset/branch sequences and
// random traffic, checked against a cycle-position model of the pipeline rules.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] Rs1BH, Rs2BH, Rs1CH, Rs2CH, RdCH, RdDH, RdEH;
  logic MemReadCH, MultiCycleCH, PCSrcCH, RegWriteDH, RegWriteEH;

  logic [1:0] fa1, fb1, fa2, fb2;
  logic sa1, sb1, sc1, flB1, flC1, flD1, busy1;
  logic sa2, sb2, sc2, flB2, flC2, flD2, busy2;
  logic [15:0] cnt1;
  logic [3:0]  cnt2;

  hazard_ctrl #(.ADDR_WIDTH(5), .MC_LATENCY(4), .CNT_WIDTH(16)) u1 (
    .clk(clk), .rst_n(rst_n), .Rs1BH(Rs1BH), .Rs2BH(Rs2BH), .Rs1CH(Rs1CH), .Rs2CH(Rs2CH),
    .RdCH(RdCH), .MemReadCH(MemReadCH), .MultiCycleCH(MultiCycleCH), .PCSrcCH(PCSrcCH),
    .RdDH(RdDH), .RegWriteDH(RegWriteDH), .RdEH(RdEH), .RegWriteEH(RegWriteEH),
    .ForwardAH(fa1), .ForwardBH(fb1), .StallAH(sa1), .StallBH(sb1), .StallCH(sc1),
    .FlushBH(flB1), .FlushCH(flC1), .FlushDH(flD1), .BusyH(busy1), .StallCntH(cnt1));

  hazard_ctrl #(.ADDR_WIDTH(5), .MC_LATENCY(1), .CNT_WIDTH(4)) u2 (
    .clk(clk), .rst_n(rst_n), .Rs1BH(Rs1BH), .Rs2BH(Rs2BH), .Rs1CH(Rs1CH), .Rs2CH(Rs2CH),
    .RdCH(RdCH), .MemReadCH(MemReadCH), .MultiCycleCH(MultiCycleCH), .PCSrcCH(PCSrcCH),
    .RdDH(RdDH), .RegWriteDH(RegWriteDH), .RdEH(RdEH), .RegWriteEH(RegWriteEH),
    .ForwardAH(fa2), .ForwardBH(fb2), .StallAH(sa2), .StallBH(sb2), .StallCH(sc2),
    .FlushBH(flB2), .FlushCH(flC2), .FlushDH(flD2), .BusyH(busy2), .StallCntH(cnt2));

  typedef struct {
    logic [4:0] rs1B, rs2B, rs1C, rs2C, rdC;
    logic       memRead, multi, pcSrc;
    logic [4:0] rdD;
    logic       regWD;
    logic [4:0] rdE;
    logic       regWE;
  } in_t;

  typedef struct {
    logic [1:0] fa, fb;
    logic       sa, sb, sc, flB, flC, flD, busy;
  } out_t;

  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  int checks = 0;
  int errors = 0;
  // ageN: op cycles already spent in C by the current multicycle op (0 = none)
  int age1 = 0, age2 = 0;
  int mcnt1 = 0, mcnt2 = 0;

  function automatic out_t mkOut(logic [1:0] fa, logic [1:0] fb, logic sa, logic sb,
                                 logic sc, logic flB, logic flC, logic flD, logic busy);
    out_t o;
    o.fa = fa; o.fb = fb; o.sa = sa; o.sb = sb; o.sc = sc;
    o.flB = flB; o.flC = flC; o.flD = flD; o.busy = busy;
    return o;
  endfunction

  function automatic out_t zeroOut();
    return mkOut(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic in_t idleIn();
    in_t v;
    v.rs1B = 5'd0; v.rs2B = 5'd0; v.rs1C = 5'd0; v.rs2C = 5'd0; v.rdC = 5'd0;
    v.memRead = 1'b0; v.multi = 1'b0; v.pcSrc = 1'b0;
    v.rdD = 5'd0; v.regWD = 1'b0; v.rdE = 5'd0; v.regWE = 1'b0;
    return v;
  endfunction

  function automatic logic [1:0] fwdRef(in_t v, logic [4:0] rs);
    if (v.regWD && v.rdD != 5'd0 && v.rdD == rs) return 2'b10;
    if (v.regWE && v.rdE != 5'd0 && v.rdE == rs) return 2'b01;
    return 2'b00;
  endfunction

  function automatic out_t model(in_t v, int lat, int age, logic rstn, output int nextAge);
    out_t o;
    int   pos;
    bit   mcStall;
    o = zeroOut();
    nextAge = 0;
    if (!rstn) return o;
    o.fa = fwdRef(v, v.rs1C);
    o.fb = fwdRef(v, v.rs2C);
    pos = (age == 0) ? ((v.multi && lat > 1) ? 1 : 0) : age + 1;
    mcStall = (pos >= 1 && pos <= lat - 1);
    nextAge = (pos == 0 || pos == lat) ? 0 : pos;
    o.busy = (age > 0);
    if (mcStall) begin
      o.sa = 1'b1; o.sb = 1'b1; o.sc = 1'b1; o.flD = 1'b1;
    end else if (v.pcSrc) begin
      o.flB = 1'b1; o.flC = 1'b1;
    end else if (age == 0 && v.memRead && v.rdC != 5'd0 && (v.rdC == v.rs1B || v.rdC == v.rs2B)) begin
      o.sa = 1'b1; o.sb = 1'b1; o.flC = 1'b1;
    end
    return o;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmpOut(input string tag, input out_t a, input out_t e);
    chk({tag, ".ForwardA"}, int'(a.fa), int'(e.fa));
    chk({tag, ".ForwardB"}, int'(a.fb), int'(e.fb));
    chk({tag, ".StallA"}, int'(a.sa), int'(e.sa));
    chk({tag, ".StallB"}, int'(a.sb), int'(e.sb));
    chk({tag, ".StallC"}, int'(a.sc), int'(e.sc));
    chk({tag, ".FlushB"}, int'(a.flB), int'(e.flB));
    chk({tag, ".FlushC"}, int'(a.flC), int'(e.flC));
    chk({tag, ".FlushD"}, int'(a.flD), int'(e.flD));
    chk({tag, ".Busy"}, int'(a.busy), int'(e.busy));
  endtask

  task automatic applyIn(input in_t v);
    Rs1BH = v.rs1B; Rs2BH = v.rs2B; Rs1CH = v.rs1C; Rs2CH = v.rs2C; RdCH = v.rdC;
    MemReadCH = v.memRead; MultiCycleCH = v.multi; PCSrcCH = v.pcSrc;
    RdDH = v.rdD; RegWriteDH = v.regWD; RdEH = v.rdE; RegWriteEH = v.regWE;
  endtask

  task automatic compareAll(input string tag, input out_t e1, input out_t e2);
    cmpOut({tag, "/lat4"}, mkOut(fa1, fb1, sa1, sb1, sc1, flB1, flC1, flD1, busy1), e1);
    cmpOut({tag, "/lat1"}, mkOut(fa2, fb2, sa2, sb2, sc2, flB2, flC2, flD2, busy2), e2);
    chk({tag, "/lat4.StallCnt"}, int'(cnt1), mcnt1);
    chk({tag, "/lat1.StallCnt"}, int'(cnt2), mcnt2);
  endtask

  // Drive one cycle's inputs, check against the model (or table), then advance the model.
  task automatic step(input in_t v, input bit useTab, input out_t tabExp, input string tag);
    out_t e1, e2;
    int   n1, n2;
    @(negedge clk);
    applyIn(v);
    #1;
    e1 = model(v, 4, age1, rst_n, n1);
    e2 = model(v, 1, age2, rst_n, n2);
    if (useTab) e1 = tabExp;
    compareAll(tag, e1, e2);
    age1 = n1;
    age2 = n2;
    if ((e1.sb || e1.sc) && mcnt1 < 65535) mcnt1++;
    if ((e2.sb || e2.sc) && mcnt2 < 15) mcnt2++;
  endtask

  task automatic run(input in_t v, input string tag);
    step(v, 1'b0, zeroOut(), tag);
  endtask

  task automatic doReset(input string tag);
    @(negedge clk);
    applyIn(idleIn());
    rst_n = 1'b0;
    age1 = 0; age2 = 0; mcnt1 = 0; mcnt2 = 0;
    #1;
    compareAll(tag, zeroOut(), zeroOut());
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  vec_t tab[9];
  in_t  v;

  initial begin
    applyIn(idleIn());

    v = idleIn(); v.rdD = 5; v.rdE = 5; v.regWD = 1; v.regWE = 1; v.rs1C = 5;
    tab[0] = '{v, mkOut(2'b10, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    v = idleIn(); v.regWD = 1; v.regWE = 1;
    tab[1] = '{v, mkOut(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    v = idleIn(); v.rdD = 4; v.regWD = 1; v.rdE = 3; v.regWE = 1; v.rs1C = 4; v.rs2C = 3;
    tab[2] = '{v, mkOut(2'b10, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    v = idleIn(); v.rdD = 6; v.rdE = 6; v.regWE = 1; v.rs1C = 6; v.rs2C = 6;
    tab[3] = '{v, mkOut(2'b01, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    v = idleIn(); v.memRead = 1; v.rdC = 7; v.rs2B = 7;
    tab[4] = '{v, mkOut(2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};
    v = idleIn(); v.memRead = 1;
    tab[5] = '{v, mkOut(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0)};
    v = idleIn(); v.pcSrc = 1;
    tab[6] = '{v, mkOut(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
    v = idleIn(); v.pcSrc = 1; v.memRead = 1; v.rdC = 9; v.rs1B = 9;
    tab[7] = '{v, mkOut(2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0)};
    v = idleIn(); v.memRead = 1; v.rdC = 2; v.rs1B = 2; v.rdE = 2; v.regWE = 1; v.rs2C = 2;
    tab[8] = '{v, mkOut(2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0)};

    doReset("reset0");
    for (int i = 0; i < 9; i++) step(tab[i].i, 1'b1, tab[i].o, $sformatf("tab%0d", i));

    // Multicycle op held for four cycles, then a free cycle.
    doReset("reset1");
    v = idleIn(); v.multi = 1;
    for (int i = 0; i < 4; i++) run(v, $sformatf("mc%0d", i));
    run(idleIn(), "mcAfter");
    chk("mc.StallCnt3", int'(cnt1), 3);
    chk("mc.lat1NeverBusy", int'(busy2), 0);

    // Branch during BUSY is suppressed; allowed on release and in IDLE.
    doReset("reset2");
    v = idleIn(); v.multi = 1; v.pcSrc = 1;
    for (int i = 0; i < 3; i++) run(v, $sformatf("brBusy%0d", i));
    v = idleIn(); v.pcSrc = 1;
    run(v, "brRelease");
    run(v, "brIdle");
    chk("brIdle.FlushB", int'(flB1), 1);

    // Asynchronous reset in the second stall cycle.
    doReset("reset3");
    v = idleIn(); v.multi = 1;
    run(v, "arMc0");
    @(negedge clk);
    applyIn(v);
    #1;
    chk("ar.stallBefore", int'(sc1), 1);
    chk("ar.busyBefore", int'(busy1), 1);
    rst_n = 1'b0;
    age1 = 0; age2 = 0; mcnt1 = 0; mcnt2 = 0;
    #1;
    compareAll("arLow", zeroOut(), zeroOut());
    applyIn(idleIn());
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) run(v, $sformatf("arMc%0d", i));
    chk("ar.StallCnt3", int'(cnt1), 3);

    // Counter saturation on the 4-bit instance.
    doReset("reset4");
    v = idleIn(); v.memRead = 1; v.rdC = 3; v.rs1B = 3;
    for (int i = 0; i < 20; i++) run(v, $sformatf("sat%0d", i));
    run(idleIn(), "satEnd");
    chk("sat.cnt4bit", int'(cnt2), 15);
    chk("sat.cnt16bit", int'(cnt1), 20);

    doReset("reset5");
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) doReset($sformatf("rndReset%0d", i));
      v.rs1B = 5'($urandom_range(0, 7)); v.rs2B = 5'($urandom_range(0, 7));
      v.rs1C = 5'($urandom_range(0, 7)); v.rs2C = 5'($urandom_range(0, 7));
      v.rdC  = 5'($urandom_range(0, 7)); v.rdD  = 5'($urandom_range(0, 7));
      v.rdE  = 5'($urandom_range(0, 7));
      v.memRead = ($urandom_range(0, 9) < 3);
      v.multi   = ($urandom_range(0, 9) < 2);
      v.pcSrc   = ($urandom_range(0, 19) < 3);
      v.regWD   = ($urandom_range(0, 9) < 7);
      v.regWE   = ($urandom_range(0, 9) < 7);
      run(v, $sformatf("rnd%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
